// File: rtl/vga_image_blitter_if.sv
// vga_image_blitter_if: draw request/handshake, shared image ROM bank and VGA adapter pixel stream
interface vga_image_blitter_if #(
    parameter int X_W        = 8,
    parameter int Y_W        = 7,
    parameter int ADDR_W     = 15,
    parameter int COLOUR_W   = 3,
    parameter int NUM_IMAGES = 13,
    parameter int SEL_W      = 6
);
    logic                           start;
    logic [SEL_W-1:0]               image_sel;
    logic                           busy;
    logic                           done;
    logic [ADDR_W-1:0]              rom_addr;
    logic [NUM_IMAGES*COLOUR_W-1:0] rom_q;
    logic [X_W-1:0]                 x;
    logic [Y_W-1:0]                 y;
    logic [COLOUR_W-1:0]            colour;
    logic                           plot;
    modport master (output start, image_sel, rom_q, input busy, done, rom_addr, x, y, colour, plot);
    modport slave  (input start, image_sel, rom_q, output busy, done, rom_addr, x, y, colour, plot);
endinterface

// File: rtl/vga_image_blitter.sv
// vga_image_blitter: scans a WIDTH x HEIGHT frame through a ROM bank and streams aligned pixels to the VGA adapter.
// Define TRANSPARENT_KEY_EN to suppress plotting of pixels whose colour equals KEY_COLOUR.
module vga_image_blitter #(
    parameter int WIDTH      = 160,
    parameter int HEIGHT     = 120,
    parameter int X_W        = 8,
    parameter int Y_W        = 7,
    parameter int ADDR_W     = 15,
    parameter int COLOUR_W   = 3,
    parameter int NUM_IMAGES = 13,
    parameter int SEL_W      = 6,
    parameter int ROM_LAT    = 1
`ifdef TRANSPARENT_KEY_EN
    , parameter int KEY_COLOUR = 0
`endif
) (
    input logic                  clk,
    input logic                  resetn,
    vga_image_blitter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
    state_t              state_q;
    logic [X_W-1:0]      x_cnt_q;
    logic [Y_W-1:0]      y_cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [SEL_W-1:0]    sel_q;
    logic [2:0]          lat_q;
    logic                busy_q;
    logic                done_q;
    logic                plot_q;
    logic [X_W-1:0]      x_q;
    logic [Y_W-1:0]      y_q;
    logic [COLOUR_W-1:0] colour_q;
    logic [ROM_LAT-1:0]  pv_q;
    logic [X_W-1:0]      px_q [ROM_LAT];
    logic [Y_W-1:0]      py_q [ROM_LAT];
    logic [COLOUR_W-1:0] colour_d;
    logic                plot_d;
    logic                x_last;
    logic                y_last;

    assign x_last = x_cnt_q == X_W'(WIDTH - 1);
    assign y_last = y_cnt_q == Y_W'(HEIGHT - 1);

    // Out-of-range selects match no image and fall through to colour 0.
    always_comb begin
        colour_d = '0;
        for (int i = 0; i < NUM_IMAGES; i++)
            if (sel_q == SEL_W'(i)) colour_d = bus.rom_q[i*COLOUR_W +: COLOUR_W];
    end

`ifdef TRANSPARENT_KEY_EN
    assign plot_d = pv_q[ROM_LAT-1] && colour_d != COLOUR_W'(KEY_COLOUR);
`else
    assign plot_d = pv_q[ROM_LAT-1];
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            x_cnt_q  <= '0;
            y_cnt_q  <= '0;
            addr_q   <= '0;
            sel_q    <= '0;
            lat_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            plot_q   <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            pv_q     <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                px_q[i] <= '0;
                py_q[i] <= '0;
            end
        end else begin
            // Coordinates ride alongside the ROM read so they land with their colour.
            pv_q[0] <= state_q == SCAN;
            px_q[0] <= x_cnt_q;
            py_q[0] <= y_cnt_q;
            for (int i = 1; i < ROM_LAT; i++) begin
                pv_q[i] <= pv_q[i-1];
                px_q[i] <= px_q[i-1];
                py_q[i] <= py_q[i-1];
            end
            plot_q <= plot_d;
            if (pv_q[ROM_LAT-1]) begin
                x_q      <= px_q[ROM_LAT-1];
                y_q      <= py_q[ROM_LAT-1];
                colour_q <= colour_d;
            end
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.start) begin
                    state_q <= SCAN;
                    sel_q   <= bus.image_sel;
                    x_cnt_q <= '0;
                    y_cnt_q <= '0;
                    addr_q  <= '0;
                    busy_q  <= 1'b1;
                end
                SCAN: begin
                    x_cnt_q <= x_last ? '0 : x_cnt_q + 1'b1;
                    if (x_last && !y_last) y_cnt_q <= y_cnt_q + 1'b1;
                    if (x_last && y_last) begin
                        state_q <= DRAIN;
                        lat_q   <= '0;
                    end else
                        addr_q <= addr_q + 1'b1;
                end
                // One extra cycle beyond ROM_LAT covers the output register stage.
                DRAIN: begin
                    state_q <= lat_q == 3'(ROM_LAT) ? DONE : DRAIN;
                    done_q  <= lat_q == 3'(ROM_LAT);
                    lat_q   <= lat_q + 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.rom_addr = addr_q;
    assign bus.x        = x_q;
    assign bus.y        = y_q;
    assign bus.colour   = colour_q;
    assign bus.plot     = plot_q;
endmodule

// File: tb/tb_vga_image_blitter.sv
// tb_vga_image_blitter: two blitters (ROM latency 1 and 3) on a 4x2 frame against a frame-level pixel schedule model.
module tb_vga_image_blitter;
    localparam int W = 4, H = 2, N = W * H, NI = 13, CW = 3;
`ifdef TRANSPARENT_KEY_EN
    localparam bit KEY_ON = 1'b1;
`else
    localparam bit KEY_ON = 1'b0;
`endif
    localparam int KEY = 4;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic start = 1'b0;
    logic [5:0] sel = '0;
    always #5 clk = ~clk;

    vga_image_blitter_if #(.X_W(2), .Y_W(1), .ADDR_W(3), .COLOUR_W(CW), .NUM_IMAGES(NI), .SEL_W(6)) b1 ();
    vga_image_blitter_if #(.X_W(2), .Y_W(1), .ADDR_W(3), .COLOUR_W(CW), .NUM_IMAGES(NI), .SEL_W(6)) b3 ();

    vga_image_blitter #(.WIDTH(W), .HEIGHT(H), .X_W(2), .Y_W(1), .ADDR_W(3), .COLOUR_W(CW),
                        .NUM_IMAGES(NI), .SEL_W(6), .ROM_LAT(1)
`ifdef TRANSPARENT_KEY_EN
                        , .KEY_COLOUR(KEY)
`endif
    ) dut1 (.clk(clk), .resetn(resetn), .bus(b1));

    vga_image_blitter #(.WIDTH(W), .HEIGHT(H), .X_W(2), .Y_W(1), .ADDR_W(3), .COLOUR_W(CW),
                        .NUM_IMAGES(NI), .SEL_W(6), .ROM_LAT(3)
`ifdef TRANSPARENT_KEY_EN
                        , .KEY_COLOUR(KEY)
`endif
    ) dut3 (.clk(clk), .resetn(resetn), .bus(b3));

    assign b1.start = start;
    assign b3.start = start;
    assign b1.image_sel = sel;
    assign b3.image_sel = sel;

    logic [2:0] mem [NI][N];

    function automatic logic [NI*CW-1:0] rom_word(input logic [2:0] a);
        rom_word = '0;
        for (int i = 0; i < NI; i++) rom_word[i*CW +: CW] = mem[i][a];
    endfunction

    logic [NI*CW-1:0] rd1;
    logic [NI*CW-1:0] rd3 [3];
    always @(posedge clk) begin
        rd1    <= rom_word(b1.rom_addr);
        rd3[0] <= rom_word(b3.rom_addr);
        rd3[1] <= rd3[0];
        rd3[2] <= rd3[1];
    end
    assign b1.rom_q = rd1;
    assign b3.rom_q = rd3[2];

    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    int ex[N], ey[N], ec[N];
    bit ek[N];

    task automatic load(input int s, input bit rnd);
        for (int i = 0; i < NI; i++)
            for (int a = 0; a < N; a++)
                mem[i][a] = rnd ? 3'($urandom) : 3'((a + i) % 8);
        for (int j = 0; j < N; j++) begin
            ex[j] = j % W;
            ey[j] = j / W;
            ec[j] = s < NI ? int'(mem[s][j]) : 0;
            ek[j] = KEY_ON && ec[j] == KEY;
        end
    endtask

    // Cycle k counts clock edges after the start-sampling edge; pixel j of a
    // latency-L ROM must be plotted at k = L+2+j, done at k = L+2+N.
    task automatic frame(input int s, input bit rnd, input bit mid);
        int plots[2];
        int dones[2];
        int keyed;
        load(s, rnd);
        keyed = 0;
        for (int j = 0; j < N; j++) keyed += int'(ek[j]);
        plots = '{0, 0};
        dones = '{0, 0};
        @(negedge clk);
        start = 1'b1;
        sel = 6'(s);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start = mid && k == 3;
            if (mid && k == 3) sel = '0;
            for (int d = 0; d < 2; d++) begin
                int lat, j;
                logic p, dn, bz;
                logic [31:0] px, py, pc;
                lat = d ? 3 : 1;
                p  = d ? b3.plot : b1.plot;
                dn = d ? b3.done : b1.done;
                bz = d ? b3.busy : b1.busy;
                px = d ? 32'(b3.x) : 32'(b1.x);
                py = d ? 32'(b3.y) : 32'(b1.y);
                pc = d ? 32'(b3.colour) : 32'(b1.colour);
                j = k - lat - 2;
                check("busy", 32'(bz), 32'(k <= lat + 2 + N));
                if (p) begin
                    plots[d]++;
                    check("plot_slot", (j >= 0 && j < N) ? 32'(!ek[j]) : 32'd0, 32'd1);
                    if (j >= 0 && j < N) begin
                        check("x", px, ex[j]);
                        check("y", py, ey[j]);
                        check("colour", pc, ec[j]);
                    end
                end
                if (dn) begin
                    dones[d]++;
                    check("done_cycle", k, lat + 2 + N);
                end
            end
            if (k <= N) check("rom_addr", 32'(b3.rom_addr), k - 1);
        end
        for (int d = 0; d < 2; d++) begin
            check("plot_count", plots[d], N - keyed);
            check("done_count", dones[d], 1);
        end
    endtask

    task automatic reset_mid_frame();
        load(2, 1'b0);
        @(negedge clk);
        start = 1'b1;
        sel = 6'd2;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("pre_reset_busy", 32'(b1.busy), 1);
        resetn = 1'b0;
        #1;
        check("rst_plot1", 32'(b1.plot), 0);
        check("rst_x1", 32'(b1.x), 0);
        check("rst_y1", 32'(b1.y), 0);
        check("rst_colour1", 32'(b1.colour), 0);
        check("rst_busy1", 32'(b1.busy), 0);
        check("rst_addr3", 32'(b3.rom_addr), 0);
        check("rst_busy3", 32'(b3.busy), 0);
        @(negedge clk);
        resetn = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("post_rst_quiet", {28'd0, b1.plot, b1.done, b3.plot, b3.done}, 0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("init_busy", 32'(b1.busy), 0);
        check("init_done", 32'(b3.done), 0);
        check("init_plot", 32'(b1.plot), 0);
        check("init_x", 32'(b3.x), 0);
        check("init_colour", 32'(b1.colour), 0);
        check("init_addr", 32'(b3.rom_addr), 0);
        resetn = 1'b1;
        frame(2, 1'b0, 1'b0);
        frame(2, 1'b0, 1'b1);
        frame(13, 1'b0, 1'b0);
        reset_mid_frame();
        frame(2, 1'b0, 1'b0);
        repeat (8) frame(int'($urandom_range(0, 15)), 1'b1, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_image_blitter.md
Name: vga_image_blitter

Overview:
Parametrised full-frame image blitter for the VGA adapter path. On a start pulse it scans every pixel of a WIDTH x HEIGHT frame and issues a linear address to a bank of NUM_IMAGES read-only image memories. It muxes the selected image's colour and emits pixel-aligned x/y/colour/plot to the VGA adapter. It replaces the fixed 13-way, 160x120, 3-bit screen datapath, and adds ROM-latency alignment, a start/busy/done handshake and a configurable image count and colour depth.

Parameters:
WIDTH, 160, frame width in pixels
HEIGHT, 120, frame height in pixels
X_W, 8, x coordinate width; must satisfy 2^X_W >= WIDTH
Y_W, 7, y coordinate width; must satisfy 2^Y_W >= HEIGHT
ADDR_W, 15, ROM address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT
COLOUR_W, 3, bits per pixel
NUM_IMAGES, 13, number of image ROMs in the bank
SEL_W, 6, image select width
ROM_LAT, 1, ROM read latency in cycles (1..4)
KEY_COLOUR, 0, transparent colour value (used only with the optional feature)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
start  in  1  single-cycle request to draw one frame
image_sel  in  SEL_W  image index, sampled with start
busy  out  1  high while a frame is in progress
done  out  1  one-cycle pulse after the last pixel is plotted
rom_addr  out  ADDR_W  shared address to all image ROMs, equal to y*WIDTH+x
rom_q  in  NUM_IMAGES*COLOUR_W  concatenated ROM outputs; image i occupies bits [i*COLOUR_W +: COLOUR_W]
x  out  X_W  pixel x, aligned to colour
y  out  Y_W  pixel y, aligned to colour
colour  out  COLOUR_W  pixel colour
plot  out  1  write strobe to the VGA adapter

Behaviour:
- Reset, asynchronous, at any time including mid-frame: state IDLE. busy=0, done=0, plot=0, x=0, y=0, colour=0, rom_addr=0, and all pipeline valids cleared.
- States:
  - IDLE: start=1 -> latch image_sel, clear scan counters, go to SCAN.
  - SCAN: present one address per cycle. x increments 0..WIDTH-1; at WIDTH-1 x wraps to 0 and y increments. After address (WIDTH-1, HEIGHT-1) is issued -> DRAIN.
  - DRAIN: wait ROM_LAT cycles for the pipeline to empty -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
- busy=1 in SCAN, DRAIN and DONE. start is ignored while busy=1, and the latched select does not change mid-frame.
- Address is a registered counter, rom_addr = y_cnt*WIDTH + x_cnt. The running address may increment alongside the counters instead of being recomputed by multiplication. It never exceeds WIDTH*HEIGHT-1.
- Alignment: x_cnt, y_cnt and a valid bit pass through a ROM_LAT-deep shift pipeline. The output register captures the delayed x/y plus the selected rom_q slice. The pixel whose address is issued at cycle t has plot=1 with matching x/y/colour at cycle t+ROM_LAT+1.
- Latency: start high at edge E -> first address at E+1 -> first plot at E+ROM_LAT+2. The frame produces exactly WIDTH*HEIGHT plot cycles, contiguous with no gaps. done is asserted the cycle after the final plot.
- Select out of range (latched sel >= NUM_IMAGES): frame still scans, colour=0 for every pixel, plot asserted normally.
- Outside a frame, plot=0, and x/y/colour hold their last values.

Optional Feature:
TRANSPARENT_KEY_EN
- Defined: a pixel whose selected colour equals KEY_COLOUR has plot=0 for that cycle; x/y still advance. Frame timing and done timing are unchanged. This lets sprite/overlay images be drawn over an existing screen.
- Undefined: every pixel is plotted, and KEY_COLOUR is unused.

Test Plan:
1. WIDTH=4, HEIGHT=2, ROM_LAT=1, ROM i returns (addr+i) mod 8. start with sel=2 -> 8 plots in consecutive cycles, (x,y) = (0,0),(1,0),(2,0),(3,0),(0,1)..(3,1), colour = 2,3,4,5,6,7,0,1. First plot 3 cycles after the start edge; done the cycle after the last plot.
2. Same config, ROM_LAT=3 -> identical x/y/colour sequence; first plot 5 cycles after start; rom_addr runs 0..7 once.
3. start pulsed again mid-frame with sel=0 -> ignored; colours still from image 2; exactly 8 plots; single done.
4. resetn low for one cycle at the 4th plot -> outputs zero immediately; no done; IDLE. A fresh start then gives a full 8-plot frame.
5. sel=13 with NUM_IMAGES=13 -> 8 plots, all colour=0, done asserted.
6. TRANSPARENT_KEY_EN defined, KEY_COLOUR=4, sel=2 -> plot suppressed only for pixel (2,0); 7 plots; done at the same cycle as test 1.
